// File: rtl/fpu_regfile_pkg.sv
// rtl/fpu_regfile_pkg.sv - shared sizes, select type and write-FSM states for the FPU register file
package fpu_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;

    typedef logic [SEL_W-1:0] reg_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_t;

    // One-hot mask for a register select; selects wrap naturally within SEL_W bits.
    function automatic logic [NUM_REGS-1:0] sel_mask(input reg_sel_t sel);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits: set on issue, cleared on FPU writeback, set wins
module reg_scoreboard
    import fpu_regfile_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                set_en,
    input  reg_sel_t            set_sel,
    input  logic                clr_en,
    input  reg_sel_t            clr_sel,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign set_mask = set_en ? sel_mask(set_sel) : '0;
    assign clr_mask = clr_en ? sel_mask(clr_sel) : '0;

    // Clear first, then OR in the set so an issue to the same register keeps it pending.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - register write arbiter (FPU/SRAM/host) with clear sequencer; REG_SCOREBOARD_EN enables pending tracking
module reg_write_ctrl #(
    parameter int DATA_W   = fpu_regfile_pkg::DATA_W,
    parameter int NUM_REGS = fpu_regfile_pkg::NUM_REGS
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             fpu_valid,
    input  logic [$clog2(NUM_REGS)-1:0]      fpu_dest,
    input  logic [DATA_W-1:0]                fpu_result,
    input  logic                             sram_w_en,
    input  logic [$clog2(NUM_REGS)-1:0]      sram_w_sel,
    input  logic [DATA_W-1:0]                sram_w_data,
    output logic                             sram_w_ready,
    input  logic                             host_wen,
    input  logic [$clog2(NUM_REGS)-1:0]      host_sel,
    input  logic [DATA_W-1:0]                host_data,
    output logic                             host_ready,
    input  logic                             issue_en,
    input  logic [$clog2(NUM_REGS)-1:0]      issue_dest,
    input  logic                             clear_req,
    output logic                             clear_busy,
    output logic [NUM_REGS-1:0]              pending,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);

    import fpu_regfile_pkg::*;

    localparam int SW = $clog2(NUM_REGS);

    wr_state_t      state;
    logic [SW-1:0]  clr_idx;
    logic           rr_ptr;     // 0 favours SRAM, 1 favours host
    logic           idle;
    logic           fpu_wr;
    logic           clear_ok;
    logic           sram_elig;
    logic           host_elig;
    logic           sram_grant;
    logic           host_grant;

    assign idle   = (state == IDLE);
    assign fpu_wr = fpu_valid && idle;

`ifdef REG_SCOREBOARD_EN
    logic issue_ok;
    assign issue_ok = issue_en && idle;

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .n_rst   (n_rst),
        .set_en  (issue_ok),
        .set_sel (issue_dest),
        .clr_en  (fpu_wr),
        .clr_sel (fpu_dest),
        .pending (pending)
    );

    assign clear_ok = (pending == '0);
`else
    logic unused_issue;
    assign unused_issue = ^{issue_en, issue_dest};
    assign pending      = '0;
    assign clear_ok     = 1'b1;
`endif

    // Eligibility then round-robin grant; FPU always wins its own destination.
    always_comb begin
        sram_elig  = n_rst && idle && sram_w_en && !pending[sram_w_sel]
                     && !(fpu_valid && (fpu_dest == sram_w_sel));
        host_elig  = n_rst && idle && host_wen && !pending[host_sel]
                     && !(fpu_valid && (fpu_dest == host_sel));
        sram_grant = sram_elig && (!host_elig || !rr_ptr);
        host_grant = host_elig && (!sram_elig ||  rr_ptr);
    end

    assign sram_w_ready = sram_grant;
    assign host_ready   = host_grant;

    // Write FSM: IDLE commits granted writes, CLEAR zeroes one register per cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            clr_idx    <= '0;
            rr_ptr     <= 1'b0;
            clear_busy <= 1'b0;
            regs       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fpu_wr)
                        regs[fpu_dest] <= fpu_result;
                    if (sram_grant)
                        regs[sram_w_sel] <= sram_w_data;
                    if (host_grant)
                        regs[host_sel] <= host_data;
                    if (sram_w_en && host_wen && (sram_grant || host_grant))
                        rr_ptr <= ~rr_ptr;
                    if (clear_req && clear_ok) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        clr_idx    <= '0;
                    end
                end
                CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 1'b1;
                    if (clr_idx == SW'(NUM_REGS - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb/tb_reg_write_ctrl.sv - directed and randomized self-checking bench for reg_write_ctrl
module tb_reg_write_ctrl;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               fpu_valid;
    logic [3:0]         fpu_dest;
    logic [31:0]        fpu_result;
    logic               sram_w_en;
    logic [3:0]         sram_w_sel;
    logic [31:0]        sram_w_data;
    logic               sram_w_ready;
    logic               host_wen;
    logic [3:0]         host_sel;
    logic [31:0]        host_data;
    logic               host_ready;
    logic               issue_en;
    logic [3:0]         issue_dest;
    logic               clear_req;
    logic               clear_busy;
    logic [15:0]        pending;
    logic [15:0][31:0]  regs;

    always #5 clk = ~clk;

    reg_write_ctrl #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fpu_valid    (fpu_valid),
        .fpu_dest     (fpu_dest),
        .fpu_result   (fpu_result),
        .sram_w_en    (sram_w_en),
        .sram_w_sel   (sram_w_sel),
        .sram_w_data  (sram_w_data),
        .sram_w_ready (sram_w_ready),
        .host_wen     (host_wen),
        .host_sel     (host_sel),
        .host_data    (host_data),
        .host_ready   (host_ready),
        .issue_en     (issue_en),
        .issue_dest   (issue_dest),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .pending      (pending),
        .regs         (regs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    bit          m_ptr;
    int          m_left;
    bit          exp_s;
    bit          exp_h;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] m_pack();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = m_regs[i];
        return p;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_pend = 16'h0;
        m_ptr  = 1'b0;
        m_left = 0;
    endtask

    task automatic predict();
        bit es, eh;
        es = 0;
        eh = 0;
        if (n_rst && m_left == 0) begin
            es = sram_w_en && !m_pend[sram_w_sel] && !(fpu_valid && fpu_dest == sram_w_sel);
            eh = host_wen  && !m_pend[host_sel]   && !(fpu_valid && fpu_dest == host_sel);
        end
        if (es && eh) begin
            exp_s = !m_ptr;
            exp_h = m_ptr;
        end else begin
            exp_s = es;
            exp_h = eh;
        end
    endtask

    task automatic m_update();
        bit go;
        if (!n_rst) begin
            m_reset();
            return;
        end
        if (m_left > 0) begin
            m_regs[16 - m_left] = 32'h0;
            m_left--;
        end else begin
            go = clear_req && (m_pend == 16'h0);
            if (fpu_valid) m_regs[fpu_dest]   = fpu_result;
            if (exp_s)     m_regs[sram_w_sel] = sram_w_data;
            if (exp_h)     m_regs[host_sel]   = host_data;
            if (sram_w_en && host_wen && (exp_s || exp_h)) m_ptr = !m_ptr;
`ifdef REG_SCOREBOARD_EN
            if (fpu_valid) m_pend[fpu_dest]   = 1'b0;
            if (issue_en)  m_pend[issue_dest] = 1'b1;
`endif
            if (go) m_left = 16;
        end
    endtask

    // called shortly after a rising edge with inputs already driven
    task automatic cycle();
        if (!n_rst) m_reset();
        #3;
        predict();
        check("sram_w_ready", sram_w_ready, exp_s);
        check("host_ready",   host_ready,   exp_h);
        check("clear_busy",   clear_busy,   m_left > 0);
        check("pending",      pending,      m_pend);
        check("regs",         regs,         m_pack());
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle_inputs();
        fpu_valid = 0; fpu_dest = 0; fpu_result = 0;
        sram_w_en = 0; sram_w_sel = 0; sram_w_data = 0;
        host_wen = 0; host_sel = 0; host_data = 0;
        issue_en = 0; issue_dest = 0; clear_req = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            host_wen  = 1;
            host_sel  = 4'(i);
            host_data = $urandom | 32'h1;
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        int   busy_cnt;
        bit   hold_s, hold_h;
        logic [31:0] d;

        m_reset();
        idle_inputs();
        n_rst     = 0;
        sram_w_en = 1;
        host_wen  = 1;
        #1;
        cycle();
        cycle();
        check("rst_regs", regs, 512'h0);
        check("rst_sram_ready", sram_w_ready, 1'b0);
        check("rst_host_ready", host_ready, 1'b0);
        check("rst_busy", clear_busy, 1'b0);
        n_rst = 1;
        idle_inputs();
        cycle();

        // host write without contention
        host_wen = 1; host_sel = 3; host_data = 32'hDEADBEEF;
        #2 check("r026_ready", host_ready, 1'b1);
        cycle();
        idle_inputs();
        check("r026_reg3", regs[3], 32'hDEADBEEF);

        // round-robin between SRAM and host
        sram_w_en = 1; sram_w_sel = 5; sram_w_data = 32'h5555_0001;
        host_wen  = 1; host_sel   = 6; host_data   = 32'h6666_0001;
        #2 check("r027_r1_sram", sram_w_ready, 1'b1);
        check("r027_r1_host", host_ready, 1'b0);
        cycle();
        sram_w_data = 32'h5555_0002;
        #2 check("r027_r2_sram", sram_w_ready, 1'b0);
        check("r027_r2_host", host_ready, 1'b1);
        cycle();
        idle_inputs();
        check("r027_reg5", regs[5], 32'h5555_0001);
        check("r027_reg6", regs[6], 32'h6666_0001);

        // FPU collision on the host target
        fpu_valid = 1; fpu_dest = 7; fpu_result = 32'h3F800000;
        host_wen  = 1; host_sel = 7; host_data  = 32'hABCD1234;
        #2 check("r028_host_blocked", host_ready, 1'b0);
        cycle();
        check("r028_reg7_fpu", regs[7], 32'h3F800000);
        fpu_valid = 0;
        #2 check("r028_host_retry", host_ready, 1'b1);
        cycle();
        idle_inputs();
        check("r028_reg7_host", regs[7], 32'hABCD1234);

`ifdef REG_SCOREBOARD_EN
        // pending blocks SRAM until writeback
        issue_en = 1; issue_dest = 2;
        cycle();
        issue_en = 0;
        sram_w_en = 1; sram_w_sel = 2; sram_w_data = 32'h0202_0202;
        for (int i = 0; i < 3; i++) begin
            #2 check("r029_blocked", sram_w_ready, 1'b0);
            cycle();
        end
        fpu_valid = 1; fpu_dest = 2; fpu_result = 32'h4000_0000;
        cycle();
        fpu_valid = 0;
        #2 check("r029_accept", sram_w_ready, 1'b1);
        cycle();
        idle_inputs();
        check("r029_reg2", regs[2], 32'h0202_0202);
`endif

        // full clear sequence
        fill();
        clear_req = 1;
        cycle();
        clear_req = 0;
        busy_cnt = clear_busy ? 1 : 0;
        for (int i = 0; i < 39; i++) begin
            cycle();
            if (clear_busy) busy_cnt++;
        end
        check("r030_busy_cycles", busy_cnt, 16);
        check("r030_regs_zero", regs, 512'h0);

        // reset mid-clear
        fill();
        clear_req = 1;
        cycle();
        clear_req = 0;
        repeat (8) cycle();
        #1 n_rst = 0;
        #1 check("r031_busy", clear_busy, 1'b0);
        check("r031_regs_zero", regs, 512'h0);
        m_reset();
        cycle();
        n_rst = 1;
        host_wen = 1; host_sel = 9; host_data = 32'h0909_0909;
        cycle();
        idle_inputs();
        check("r031_resume", regs[9], 32'h0909_0909);

        // randomized traffic; blocked requests are held by their source
        for (int c = 0; c < 3000; c++) begin
            hold_s = sram_w_en && !exp_s && n_rst;
            hold_h = host_wen  && !exp_h && n_rst;
            n_rst  = ($urandom_range(0, 499) != 0);
            if (!hold_s) begin
                sram_w_en   = $urandom_range(0, 1);
                sram_w_sel  = 4'($urandom_range(0, 15));
                sram_w_data = $urandom;
            end
            if (!hold_h) begin
                host_wen  = $urandom_range(0, 1);
                host_sel  = 4'($urandom_range(0, 15));
                host_data = $urandom;
            end
            fpu_valid  = ($urandom_range(0, 2) == 0);
            fpu_dest   = 4'($urandom_range(0, 15));
            d          = $urandom;
            fpu_result = d;
            issue_en   = ($urandom_range(0, 3) == 0);
            issue_dest = 4'($urandom_range(0, 15));
            clear_req  = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, register width in bits.
REQ-002 Parameter: NUM_REGS, 16, register count; the select width is 4.
REQ-003 Ports shall be (name, direction, width, meaning):
- clk, in, 1, single clock; one clock, and all state changes on rising clk.
- n_rst, in, 1, asynchronous active-low reset.
- fpu_valid, in, 1, FPU result write request; always accepted.
- fpu_dest, in, 4, FPU destination register.
- fpu_result, in, 32, FPU result data.
- sram_w_en, in, 1, SRAM load write request.
- sram_w_sel, in, 4, SRAM load destination register.
- sram_w_data, in, 32, SRAM load data.
- sram_w_ready, out, 1, SRAM write accepted this cycle.
- host_wen, in, 1, host DataIn write request.
- host_sel, in, 4, host destination register.
- host_data, in, 32, host write data.
- host_ready, out, 1, host write accepted this cycle.
- issue_en, in, 1, an FPU operation issued; marks issue_dest pending.
- issue_dest, in, 4, destination register of the issued operation.
- clear_req, in, 1, request to zero all registers.
- clear_busy, out, 1, clear sequence in progress.
- pending, out, 16, per-register pending (scoreboard) bits.
- regs, out, 16x32 packed, register contents driving the read-side output select.

Function
REQ-004 An accepted write shall update the register on the next rising clk; there is no combinational bypass.
REQ-005 fpu_valid shall always be written; in the same cycle it shall block any SRAM or host write to the same fpu_dest.
REQ-006 SRAM and host requests shall be arbitrated round-robin with a 1-bit pointer; the pointer toggles only when both request in the same cycle and one is granted.
REQ-007 A SRAM or host request shall not be accepted (ready low) when its target register's pending bit is 1.
REQ-008 A SRAM or host request shall not be accepted when it loses arbitration or collides with an FPU write to the same register.
REQ-009 Ready outputs shall be combinational from the current requests and state; a request with ready low shall be held by its source.
REQ-010 issue_en shall set pending[issue_dest] on the next cycle.
REQ-011 fpu_valid shall clear pending[fpu_dest] on the next cycle.
REQ-012 If issue_en and fpu_valid target the same register in the same cycle, the pending bit shall end at 1 (set wins).
REQ-013 FSM states: IDLE and CLEAR.
REQ-014 IDLE->CLEAR when clear_req=1 and pending==0; clear_req while any pending bit is set shall wait in IDLE.
REQ-015 CLEAR shall zero one register per cycle, index 0..15 via a 4-bit counter, then return to IDLE after index 15 (16 cycles).
REQ-016 In CLEAR: clear_busy=1, both ready outputs low, issue_en ignored.
REQ-017 In CLEAR, fpu_valid is illegal and shall be ignored.
REQ-018 Select values shall wrap naturally within 4 bits; no out-of-range case exists.

Reset
REQ-019 While n_rst=0, asynchronously: all regs 0, pending 0, FSM IDLE, counter 0, RR pointer favouring SRAM, clear_busy 0.
REQ-020 While n_rst=0, both ready outputs shall be 0.
REQ-021 A reset asserted mid-CLEAR shall abort the sequence; operation resumes in IDLE.

Configuration
REQ-022 With macro REG_SCOREBOARD_EN defined, pending tracking per REQ-007 and REQ-010..012 shall be active.
REQ-023 Without REG_SCOREBOARD_EN, pending shall be tied to 0, issue_en/issue_dest shall be ignored, and CLEAR entry shall require only clear_req.

Structure
REQ-024 Package fpu_regfile_pkg shall hold DATA_W, NUM_REGS, the reg_sel_t 4-bit typedef, and the wr_state_t enum (IDLE, CLEAR).
REQ-025 The scoreboard shall be a sub-module named reg_scoreboard, instantiated only under REG_SCOREBOARD_EN.

Verification
REQ-026 Host write sel=3 data=0xDEADBEEF with no contention -> host_ready=1; regs[3]=0xDEADBEEF one cycle later.
REQ-027 SRAM sel=5 and host sel=6 requested together twice -> SRAM granted first, host second; pointer alternates.
REQ-028 fpu_valid dest=7 result=0x3F800000 with host sel=7 in the same cycle -> host_ready=0, regs[7]=0x3F800000; host written next cycle.
REQ-029 issue_en dest=2, then SRAM sel=2 -> sram_w_ready=0 until fpu_valid dest=2 clears pending[2]; SRAM accepted the following cycle.
REQ-030 clear_req with regs nonzero and pending 0 -> clear_busy high for exactly 16 cycles; all regs 0 afterwards.
REQ-031 n_rst pulsed low at CLEAR index 8 -> FSM IDLE immediately; registers 9..15 also zero.
